alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, internal datapath 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts command; high only in IDLE.
REQ-006 cmd_op  input  2  operation: ADD=2'd0, SUB=2'd1, NAND=2'd2, 2'd3 illegal.
REQ-007 cmd_a  input  16  first operand.
REQ-008 cmd_b  input  16  second operand.
REQ-009 rsp_valid  output  1  result present.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_data  output  16  result word.
REQ-012 rsp_zero  output  1  rsp_data == 16'h0000.
REQ-013 rsp_carry  output  1  16-bit carry / no-borrow flag.

Function
REQ-014 Accept = cmd_valid & cmd_ready at a rising edge; op, a, b SHALL be latched then; later changes on cmd_* SHALL be ignored.
REQ-015 FSM states IDLE, LO, HI, FIX, DONE; IDLE->LO on accept; LO->HI always; HI->FIX if fix needed else DONE; FIX->DONE; DONE->IDLE on rsp_ready.
REQ-016 Every 8-bit pass SHALL use one 8-bit ALU computation: ADD out=a+b, carry=bit 8 of sum; SUB out=a-b mod 256, carry=1 iff a>=b unsigned; NAND out=~(a&b), carry=0.
REQ-017 LO: ALU on a[7:0], b[7:0]; capture res[7:0] and c_lo.
REQ-018 HI: ALU on a[15:8], b[15:8]; capture res[15:8] and c_hi.
REQ-019 ADD: fix needed iff c_lo=1; FIX computes res[15:8]+1 via ALU ADD with b=8'h01; final carry = c_hi | c_fix.
REQ-020 SUB: fix needed iff c_lo=0 (borrow); FIX computes res[15:8]-1 via ALU SUB with b=8'h01; final carry = c_hi & c_fix.
REQ-021 NAND: never fix; final carry = 0.
REQ-022 Illegal op: passes run without fix; response rsp_data=16'h0000, rsp_zero=1, rsp_carry=0.
REQ-023 rsp_zero SHALL be computed on full 16-bit final result, not on either byte flag.
REQ-024 Latency: accept in cycle 0 -> rsp_valid high in cycle 3 without fix, cycle 4 with fix.
REQ-025 rsp_valid, rsp_data, rsp_zero, rsp_carry SHALL stay stable while rsp_valid & !rsp_ready.
REQ-026 rsp_valid SHALL drop the cycle after rsp_valid & rsp_ready; cmd_ready rises in that same cycle (no same-cycle turnaround).
REQ-027 cmd_valid while busy SHALL be held off by cmd_ready=0; no command lost or queued.

Reset
REQ-028 rst SHALL force state IDLE, rsp_valid=0, rsp_data=16'h0000, rsp_zero=0, rsp_carry=0, cmd_ready=1 in the next cycle.
REQ-029 rst in any state including mid-operation SHALL abort the operation; no response for it ever appears.
REQ-030 rst has priority over accept and over response handshake in the same cycle.

Structure
REQ-031 Op encoding and FSM state enum SHALL live in shared package alu_seq_pkg.
REQ-032 One sub-module: the existing 8-bit combinational ALU (ops ADD/SUB/NAND, outputs zero, carry), instantiated once and time-shared across passes via operand/op muxes.

Verification
REQ-033 ADD a=16'h00FF b=16'h0001 -> rsp_data=16'h0100, carry=0, zero=0, rsp_valid in cycle 4 (FIX taken).
REQ-034 ADD a=16'hFFFF b=16'h0001 -> rsp_data=16'h0000, carry=1, zero=1.
REQ-035 SUB 16'h0003-16'h0005 -> 16'hFFFE, carry=0, zero=0; SUB 16'h1234-16'h1234 -> 16'h0000, carry=1, zero=1, cycle 3.
REQ-036 NAND a=16'hF0F0 b=16'hFF00 -> 16'h0FFF, carry=0, zero=0, rsp_valid in cycle 3.
REQ-037 rsp_ready low 5 cycles with cmd_valid held high -> outputs stable, cmd_ready=0, second command accepted only after handshake.
REQ-038 rst asserted in HI during ADD -> next cycle rsp_valid=0, cmd_ready=1, all outputs zero; no response emitted.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the byte-serial 16-bit ALU sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_NAND = 2'd2,
      OP_ILL  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int unsigned OPW = 16;
   localparam int unsigned DPW = 8;

endpackage

// File: rtl/alu_seq_alu.sv
// 8-bit combinational ALU: add, subtract (carry = no-borrow), nand.
module alu_seq_alu
   import alu_seq_pkg::*;
(
   input  logic [DPW-1:0] a_i,
   input  logic [DPW-1:0] b_i,
   input  op_e            op_i,
   output logic [DPW-1:0] res_o,
   output logic           carry_o,
   output logic           zero_o
);

   logic [DPW:0] sum;

   always_comb begin
      sum     = {1'b0, a_i} + {1'b0, b_i};
      res_o   = '0;
      carry_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            res_o   = sum[DPW-1:0];
            carry_o = sum[DPW];
         end
         OP_SUB: begin
            res_o   = a_i - b_i;
            carry_o = (a_i >= b_i);
         end
         OP_NAND: res_o = ~(a_i & b_i);
         default: ;
      endcase
      zero_o = (res_o == '0);
   end

endmodule

// File: rtl/alu_seq.sv
// 16-bit ALU built from one time-shared 8-bit ALU: low byte, high byte, optional carry fix.
//  state | meaning
//  IDLE  | ready for a command
//  LO    | low byte pass
//  HI    | high byte pass
//  FIX   | propagate low-byte carry/borrow into high byte
//  DONE  | response held until consumer takes it
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           cmd_valid_i,
   output logic           cmd_ready_o,
   input  logic [1:0]     cmd_op_i,
   input  logic [OPW-1:0] cmd_a_i,
   input  logic [OPW-1:0] cmd_b_i,
   output logic           rsp_valid_o,
   input  logic           rsp_ready_i,
   output logic [OPW-1:0] rsp_data_o,
   output logic           rsp_zero_o,
   output logic           rsp_carry_o
);

   state_e           state_q, state_d;
   op_e              op_q;
   logic [OPW-1:0]   a_q, b_q;
   logic [DPW-1:0]   res_lo_q, res_hi_q;
   logic             c_lo_q, c_hi_q;
   logic [OPW-1:0]   rsp_data_q;
   logic             rsp_zero_q, rsp_carry_q;

   logic [DPW-1:0]   alu_a, alu_b, alu_res;
   op_e              alu_op;
   logic             alu_carry, alu_zero;
   logic             accept, fix_needed, load_rsp;
   logic [OPW-1:0]   fin_data;
   logic             fin_zero, fin_carry;

   assign accept     = (state_q == ST_IDLE) && cmd_valid_i;
   assign fix_needed = ((op_q == OP_ADD) && c_lo_q) || ((op_q == OP_SUB) && !c_lo_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_valid_i) state_d = ST_LO;
         ST_LO:   state_d = ST_HI;
         ST_HI:   state_d = fix_needed ? ST_FIX : ST_DONE;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: if (rsp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = op_q;
      load_rsp  = 1'b0;
      fin_carry = 1'b0;
      case (state_q)
         ST_LO: begin
            alu_a = a_q[DPW-1:0];
            alu_b = b_q[DPW-1:0];
         end
         ST_HI: begin
            alu_a     = a_q[OPW-1:DPW];
            alu_b     = b_q[OPW-1:DPW];
            load_rsp  = !fix_needed;
            fin_carry = alu_carry;
         end
         ST_FIX: begin
            alu_a     = res_hi_q;
            alu_b     = 8'h01;
            load_rsp  = 1'b1;
            fin_carry = (op_q == OP_SUB) ? (c_hi_q & alu_carry) : (c_hi_q | alu_carry);
         end
         default: ;
      endcase
      // the high byte is always the current ALU output when the response is loaded
      fin_data = {alu_res, res_lo_q};
      fin_zero = alu_zero && (res_lo_q == '0);
      if (op_q == OP_ILL) begin
         fin_data  = '0;
         fin_zero  = 1'b1;
         fin_carry = 1'b0;
      end
   end

   alu_seq_alu u_alu (
      .a_i     (alu_a),
      .b_i     (alu_b),
      .op_i    (alu_op),
      .res_o   (alu_res),
      .carry_o (alu_carry),
      .zero_o  (alu_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         res_lo_q    <= '0;
         res_hi_q    <= '0;
         c_lo_q      <= 1'b0;
         c_hi_q      <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= op_e'(cmd_op_i);
            a_q  <= cmd_a_i;
            b_q  <= cmd_b_i;
         end
         if (state_q == ST_LO) begin
            res_lo_q <= alu_res;
            c_lo_q   <= alu_carry;
         end
         if (state_q == ST_HI) begin
            res_hi_q <= alu_res;
            c_hi_q   <= alu_carry;
         end
         if (load_rsp) begin
            rsp_data_q  <= fin_data;
            rsp_zero_q  <= fin_zero;
            rsp_carry_q <= fin_carry;
         end
      end
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_zero_o  = rsp_zero_q;
   assign rsp_carry_o = rsp_carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: reference results from plain 16-bit arithmetic.
module tb_alu_seq;

   typedef struct {
      logic [15:0] data;
      logic        zero;
      logic        carry;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [15:0] cmd_a = '0;
   logic [15:0] cmd_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_zero;
   logic        rsp_carry;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   alu_seq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_a_i     (cmd_a),
      .cmd_b_i     (cmd_b),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_zero_o  (rsp_zero),
      .rsp_carry_o (rsp_carry)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      logic [16:0] s;
      e.lat = 3;
      case (op)
         2'd0: begin
            s       = {1'b0, a} + {1'b0, b};
            e.data  = s[15:0];
            e.carry = s[16];
            if ({1'b0, a[7:0]} + {1'b0, b[7:0]} > 9'd255) e.lat = 4;
         end
         2'd1: begin
            e.data  = a - b;
            e.carry = (a >= b);
            if (a[7:0] < b[7:0]) e.lat = 4;
         end
         2'd2: begin
            e.data  = ~(a & b);
            e.carry = 1'b0;
         end
         default: begin
            e.data  = 16'h0000;
            e.carry = 1'b0;
         end
      endcase
      e.zero = (e.data == 16'h0000);
      return e;
   endfunction

   // Raise cmd_valid and wait for the accepting edge; returns #1 after it with cmd_* scrambled.
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
      bit rdy;
      int n = 0;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!ok && n < 40) begin
         rdy = cmd_ready;
         @(posedge clk);
         #1;
         n++;
         if (rdy) ok = 1'b1;
      end
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_a     = 16'($urandom);
      cmd_b     = 16'($urandom);
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: cmd_ready never seen, required 1");
      end
   endtask

   // Called #1 after the accepting edge; waits for the response, optionally stalls, then handshakes.
   task automatic collect(input string name, input int stall);
      exp_t e;
      int lat = 1;
      logic [15:0] d0;
      logic z0, c0;
      bit stable = 1'b1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
      end
      checks++;
      if (rsp_data !== e.data) begin
         errors++;
         $display("FAIL %s data: got %h required %h", name, rsp_data, e.data);
      end
      checks++;
      if (rsp_zero !== e.zero) begin
         errors++;
         $display("FAIL %s zero: got %b required %b", name, rsp_zero, e.zero);
      end
      checks++;
      if (rsp_carry !== e.carry) begin
         errors++;
         $display("FAIL %s carry: got %b required %b", name, rsp_carry, e.carry);
      end
      if (stall > 0) begin
         d0 = rsp_data;
         z0 = rsp_zero;
         c0 = rsp_carry;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || cmd_ready || rsp_data !== d0 || rsp_zero !== z0 || rsp_carry !== c0)
               stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL %s stall_stable: outputs moved or cmd_ready rose during stall, required hold", name);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: rsp_valid=%b cmd_ready=%b required 0/1", name, rsp_valid, cmd_ready);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      bit ok;
      sb.push_back(model(op, a, b));
      issue(op, a, b, ok);
      if (ok) collect(name, 0);
      else void'(sb.pop_front());
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 16'h0000 || rsp_zero !== 1'b0 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL %s: valid=%b ready=%b data=%h zero=%b carry=%b required 0 1 0000 0 0",
                  name, rsp_valid, cmd_ready, rsp_data, rsp_zero, rsp_carry);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset_state");
      cmd_valid = 1'b1;
      cmd_a     = 16'h0001;
      cmd_b     = 16'h0001;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_idle_zero("reset_beats_accept");
   endtask

   task automatic test_add();
      run_op("add_00ff_0001", 2'd0, 16'h00FF, 16'h0001);
      run_op("add_ffff_0001", 2'd0, 16'hFFFF, 16'h0001);
      run_op("add_1234_0101", 2'd0, 16'h1234, 16'h0101);
   endtask

   task automatic test_sub();
      run_op("sub_0003_0005", 2'd1, 16'h0003, 16'h0005);
      run_op("sub_1234_1234", 2'd1, 16'h1234, 16'h1234);
      run_op("sub_0100_0001", 2'd1, 16'h0100, 16'h0001);
   endtask

   task automatic test_nand();
      run_op("nand_f0f0_ff00", 2'd2, 16'hF0F0, 16'hFF00);
      run_op("nand_ffff_ffff", 2'd2, 16'hFFFF, 16'hFFFF);
   endtask

   task automatic test_illegal();
      run_op("illegal_op", 2'd3, 16'h1234, 16'h5678);
   endtask

   task automatic test_back_to_back();
      bit ok;
      sb.push_back(model(2'd0, 16'h00FF, 16'h0001));
      issue(2'd0, 16'h00FF, 16'h0001, ok);
      if (!ok) begin
         void'(sb.pop_front());
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_a     = 16'h0003;
      cmd_b     = 16'h0005;
      sb.push_back(model(2'd1, 16'h0003, 16'h0005));
      collect("b2b_first_stalled", 5);
      issue(2'd1, 16'h0003, 16'h0005, ok);
      if (ok) collect("b2b_second", 0);
      else void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         logic [1:0]  op = 2'($urandom_range(0, 2));
         logic [15:0] a  = 16'($urandom);
         logic [15:0] b  = 16'($urandom);
         run_op("random", op, a, b);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 1'b0;
      issue(2'd0, 16'h00FF, 16'h0001, ok);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_zero("reset_in_hi");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_no_response: rsp_valid=1 seen, required 0");
      end
      issue(2'd2, 16'h0F0F, 16'h00FF, ok);
      while (ok && !rsp_valid) begin
         @(posedge clk);
         #1;
      end
      rst       = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b0;
      check_idle_zero("reset_beats_handshake");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_nand();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      run_op("after_reset", 2'd0, 16'h7FFF, 16'h8001);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
